// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg.
// master : upstream/downstream driver side (drives in_valid, in_data, out_ready,
//          flush, cnt_clr; observes in_ready, out_valid, out_data, counters)
// slave  : the pipeline stage itself (opposite directions)
interface pipe_skid_reg_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              flush;
    logic              cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output in_valid, in_data, out_ready, flush, cnt_clr,
        input  in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, flush, cnt_clr,
        output in_ready, out_valid, out_data, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline register with a one-entry skid buffer, flush and stall/flush
// statistics counters.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus.slave  in_valid/in_data/in_ready (upstream), out_valid/out_data/
//              out_ready (downstream), flush, cnt_clr, stall_cnt, flush_cnt
// All outputs come straight from flops; payload flops hold BUBBLE_VAL
// whenever their valid bit is clear, so out_data needs no output mux.
module pipe_skid_reg #(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int unsigned       CNT_W      = 16
) (
    input logic            clk,
    input logic            rst,
    pipe_skid_reg_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid, main_valid_n;
    logic [DATA_W-1:0] main_data,  main_data_n;
    logic              skid_valid, skid_valid_n;
    logic [DATA_W-1:0] skid_data,  skid_data_n;
    logic              in_ready_q, in_ready_n;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_n;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_n;

    logic accept;
    logic send;

    assign accept = bus.in_valid && in_ready_q;
    assign send   = main_valid && bus.out_ready;

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid  <= 1'b0;
            main_data   <= BUBBLE_VAL;
            skid_valid  <= 1'b0;
            skid_data   <= BUBBLE_VAL;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_valid  <= main_valid_n;
            main_data   <= main_data_n;
            skid_valid  <= skid_valid_n;
            skid_data   <= skid_data_n;
            in_ready_q  <= in_ready_n;
            stall_cnt_q <= stall_cnt_n;
            flush_cnt_q <= flush_cnt_n;
        end
    end

    // Datapath next state
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;

        if (bus.flush) begin
            main_valid_n = 1'b0;
            main_data_n  = BUBBLE_VAL;
            skid_valid_n = 1'b0;
            skid_data_n  = BUBBLE_VAL;
        end else if (!main_valid) begin
            // skid is never occupied while main is empty
            if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = bus.in_data;
            end
        end else if (send) begin
            if (accept) begin
                // accept implies skid empty, so the new beat goes straight to main
                main_data_n = bus.in_data;
            end else if (skid_valid) begin
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
                skid_data_n  = BUBBLE_VAL;
            end else begin
                main_valid_n = 1'b0;
                main_data_n  = BUBBLE_VAL;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = bus.in_data;
        end

        // registered ready: low exactly while skid will hold a beat
        in_ready_n = !skid_valid_n;
    end

    // Saturating statistics counters; clear wins over increment
    always_comb begin
        stall_cnt_n = stall_cnt_q;
        flush_cnt_n = flush_cnt_q;

        if (bus.cnt_clr) begin
            stall_cnt_n = '0;
            flush_cnt_n = '0;
        end else begin
            if (main_valid && !bus.out_ready && !bus.flush && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_n = stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush && (main_valid || skid_valid) && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_n = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: a queue-based model of the held
// beats is compared against two DUTs (16-bit and 4-bit counters) every cycle,
// plus directed hand-computed checks.
module tb_pipe_skid_reg;
    localparam int unsigned DW = 64;

    logic clk;
    logic rst;

    pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(16)) bus16 ();
    pipe_skid_reg_if #(.DATA_W(DW), .CNT_W(4))  bus4  ();

    pipe_skid_reg #(.DATA_W(DW), .CNT_W(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    pipe_skid_reg #(.DATA_W(DW), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // model: beats held in the stage, oldest first, plus unbounded event counts
    logic [DW-1:0] mq[$];
    int            m_stall = 0;
    int            m_flush = 0;
    bit            m_acc;
    bit            m_snd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model update from the same inputs the DUTs see
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_stall = 0;
            m_flush = 0;
        end else begin
            m_acc = bus16.in_valid && (mq.size() < 2);
            m_snd = (mq.size() > 0) && bus16.out_ready;
            if (bus16.cnt_clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                if ((mq.size() > 0) && !bus16.out_ready && !bus16.flush) m_stall++;
                if (bus16.flush && (mq.size() > 0)) m_flush++;
            end
            if (bus16.flush) begin
                mq.delete();
            end else begin
                if (m_snd) void'(mq.pop_front());
                if (m_acc) mq.push_back(bus16.in_data);
            end
        end
    end

    // Per-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [DW-1:0] ed;
            logic          ev;
            logic          er;
            ev = (mq.size() > 0);
            ed = ev ? mq[0] : '0;
            er = (mq.size() < 2);
            chk("out_valid16", DW'(bus16.out_valid), DW'(ev));
            chk("out_data16",  bus16.out_data, ed);
            chk("in_ready16",  DW'(bus16.in_ready), DW'(er));
            chk("stall16",     DW'(bus16.stall_cnt), DW'(sat(m_stall, 16)));
            chk("flushc16",    DW'(bus16.flush_cnt), DW'(sat(m_flush, 16)));
            chk("out_valid4",  DW'(bus4.out_valid), DW'(ev));
            chk("out_data4",   bus4.out_data, ed);
            chk("in_ready4",   DW'(bus4.in_ready), DW'(er));
            chk("stall4",      DW'(bus4.stall_cnt), DW'(sat(m_stall, 4)));
            chk("flushc4",     DW'(bus4.flush_cnt), DW'(sat(m_flush, 4)));
        end
    end

    // Apply one cycle of inputs to both DUTs; returns at the following negedge
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic clr);
        bus16.in_valid = v;    bus4.in_valid = v;
        bus16.in_data = d;     bus4.in_data = d;
        bus16.out_ready = ordy; bus4.out_ready = ordy;
        bus16.flush = fl;      bus4.flush = fl;
        bus16.cnt_clr = clr;   bus4.cnt_clr = clr;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus16.in_valid = 1'b0;  bus4.in_valid = 1'b0;
        bus16.in_data = '0;     bus4.in_data = '0;
        bus16.out_ready = 1'b0; bus4.out_ready = 1'b0;
        bus16.flush = 1'b0;     bus4.flush = 1'b0;
        bus16.cnt_clr = 1'b0;   bus4.cnt_clr = 1'b0;

        // reset with no clock edge yet
        #2;
        chk("rst_out_valid", DW'(bus16.out_valid), '0);
        chk("rst_out_data",  bus16.out_data, '0);
        chk("rst_in_ready",  DW'(bus16.in_ready), DW'(1));
        chk("rst_stall",     DW'(bus16.stall_cnt), '0);
        chk("rst_flushc",    DW'(bus16.flush_cnt), '0);

        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;

        // streaming at full rate
        drive(1'b1, 64'hAAAA_0000_0000_00A1, 1'b1, 1'b0, 1'b0);
        chk("a1", bus16.out_data, 64'hAAAA_0000_0000_00A1);
        drive(1'b1, 64'hAAAA_0000_0000_00A2, 1'b1, 1'b0, 1'b0);
        chk("a2", bus16.out_data, 64'hAAAA_0000_0000_00A2);
        chk("a2_ready", DW'(bus16.in_ready), DW'(1));
        drive(1'b1, 64'hAAAA_0000_0000_00A3, 1'b1, 1'b0, 1'b0);
        chk("a3", bus16.out_data, 64'hAAAA_0000_0000_00A3);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("a_drain", DW'(bus16.out_valid), '0);
        chk("a_stall", DW'(bus16.stall_cnt), '0);

        // backpressure fills skid
        drive(1'b1, 64'hBBBB_0000_0000_00B1, 1'b0, 1'b0, 1'b0);
        chk("b1_out", bus16.out_data, 64'hBBBB_0000_0000_00B1);
        drive(1'b1, 64'hBBBB_0000_0000_00B2, 1'b0, 1'b0, 1'b0);
        chk("b2_hold", bus16.out_data, 64'hBBBB_0000_0000_00B1);
        chk("b2_ready", DW'(bus16.in_ready), '0);
        chk("b2_stall", DW'(bus16.stall_cnt), DW'(1));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("b_stall2", DW'(bus16.stall_cnt), DW'(2));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("b2_out", bus16.out_data, 64'hBBBB_0000_0000_00B2);
        chk("b2_ready_back", DW'(bus16.in_ready), DW'(1));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("b_drain", DW'(bus16.out_valid), '0);

        // flush with two held beats and a new beat offered
        drive(1'b1, 64'hCCCC_0000_0000_00C0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hCCCC_0000_0000_00CF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'hCCCC_0000_0000_00C1, 1'b0, 1'b1, 1'b0);
        chk("c_valid", DW'(bus16.out_valid), '0);
        chk("c_data", bus16.out_data, '0);
        chk("c_ready", DW'(bus16.in_ready), DW'(1));
        chk("c_flushc", DW'(bus16.flush_cnt), DW'(1));
        chk("c_stall", DW'(bus16.stall_cnt), DW'(3));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("c1_gone", DW'(bus16.out_valid), '0);

        // flush while empty does not count
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("empty_flush", DW'(bus16.flush_cnt), DW'(1));

        // send completes in a flush cycle; offered beat is discarded
        drive(1'b1, 64'h6666_0000_0000_0061, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 64'h6666_0000_0000_0062, 1'b1, 1'b1, 1'b0);
        chk("g_valid", DW'(bus16.out_valid), '0);
        chk("g_flushc", DW'(bus16.flush_cnt), DW'(2));

        // long stall saturates the 4-bit counter
        drive(1'b1, 64'hEEEE_0000_0000_00E1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("sat4", DW'(bus4.stall_cnt), DW'(15));
        chk("sat16", DW'(bus16.stall_cnt), DW'(23));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("clr4", DW'(bus4.stall_cnt), '0);
        chk("clr16", DW'(bus16.stall_cnt), '0);
        chk("clr_flushc", DW'(bus16.flush_cnt), '0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("after_clr", DW'(bus4.stall_cnt), DW'(1));

        // reset between edges with skid full
        drive(1'b1, 64'hFFFF_0000_0000_00F1, 1'b0, 1'b0, 1'b0);
        chk("f_full", DW'(bus16.in_ready), '0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", DW'(bus16.out_valid), '0);
        chk("mid_rst_ready", DW'(bus16.in_ready), DW'(1));
        chk("mid_rst_data", bus16.out_data, '0);
        #1 rst = 1'b0;
        drive(1'b1, 64'hDDDD_0000_0000_00D1, 1'b1, 1'b0, 1'b0);
        chk("d1", bus16.out_data, 64'hDDDD_0000_0000_00D1);
        chk("d1_valid", DW'(bus16.out_valid), DW'(1));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("d_drain", DW'(bus16.out_valid), '0);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the payload width (packed NPC and IR = 64).
REQ-002 Parameter BUBBLE_VAL, default all-zero DATA_W bits, SHALL be the payload value driven when no entry is valid.
REQ-003 Parameter CNT_W, default 16, SHALL set the width of each statistics counter.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in_valid  in  1  upstream beat present.
REQ-007 in_data  in  DATA_W  upstream payload.
REQ-008 in_ready  out  1  stage can accept; SHALL be driven directly from a flop.
REQ-009 out_valid  out  1  downstream beat present.
REQ-010 out_data  out  DATA_W  downstream payload.
REQ-011 out_ready  in  1  downstream accepts.
REQ-012 flush  in  1  synchronous kill of all held beats.
REQ-013 cnt_clr  in  1  synchronous clear of both counters.
REQ-014 stall_cnt  out  CNT_W  saturating count of stalled cycles.
REQ-015 flush_cnt  out  CNT_W  saturating count of effective flushes.

Function
REQ-016 Storage SHALL be one main entry (drives out_*) and one skid entry, each holding a valid bit and a payload.
REQ-017 Accept SHALL occur when in_valid && in_ready; send SHALL occur when out_valid && out_ready.
REQ-018 out_valid SHALL equal the main valid bit; out_data SHALL equal the main payload when valid and BUBBLE_VAL otherwise.
REQ-019 Latency SHALL be exactly 1 cycle from accept to out_valid when the stage is empty; throughput SHALL be 1 beat per cycle while out_ready is held high.
REQ-020 Empty + accept: the beat SHALL load into main.
REQ-021 Main valid + send + accept: the new beat SHALL replace main.
REQ-022 Main valid + send + no accept: main SHALL load skid if skid is valid, else main SHALL become invalid.
REQ-023 Main valid + no send + accept: the beat SHALL load into skid.
REQ-024 in_ready next-state SHALL be the inverse of skid valid next-state, so in_ready is low exactly while skid holds a beat.
REQ-025 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by flush.
REQ-026 flush SHALL have priority over all other updates: both valid bits SHALL clear, both payloads SHALL load BUBBLE_VAL, and in_ready SHALL be 1 next cycle.
REQ-027 A beat accepted in a flush cycle SHALL be discarded.
REQ-028 A send in a flush cycle SHALL complete normally downstream.
REQ-029 stall_cnt SHALL increment on each cycle with out_valid && !out_ready && !flush.
REQ-030 flush_cnt SHALL increment on each flush cycle in which main or skid is valid.
REQ-031 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 cnt_clr SHALL zero both counters and SHALL override any increment in the same cycle.
REQ-033 Counter updates SHALL NOT affect the datapath.

Reset
REQ-034 On rst asserted: both valid bits SHALL be 0, both payloads BUBBLE_VAL, in_ready 1, stall_cnt 0, flush_cnt 0, independent of clk.
REQ-035 Reset asserted mid-transfer SHALL discard all held beats; the first rising edge after deassertion SHALL behave as the empty state.

Verification
REQ-036 Assert rst without clock -> out_valid=0, out_data=0, in_ready=1, stall_cnt=0, flush_cnt=0.
REQ-037 out_ready=1, beats 0x...A1, A2, A3 on consecutive cycles -> same values on out_data one cycle later each, in_ready stays 1, stall_cnt=0.
REQ-038 out_ready=0, push B1 then B2 -> out_data=B1 held, in_ready=0 from the cycle after B2, stall_cnt counts; raise out_ready -> B1, then B2, in_ready=1 after B2 reaches main.
REQ-039 Two beats held, flush=1 with in_valid=1 and C1 -> next cycle out_valid=0, out_data=0, in_ready=1, flush_cnt=1, C1 never appears.
REQ-040 CNT_W=4, out_valid held with out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr=1 with the stall still present -> 0 next cycle.
REQ-041 rst pulsed between clock edges while skid is full -> immediately out_valid=0, in_ready=1; a subsequent beat D1 passes with 1-cycle latency.
